// File: rtl/cdf_builder_if.sv
// cdf_builder_if: start/bank control, histogram read-clear port, CDF write port and result signals
interface cdf_builder_if;
  logic        cdf_start;
  logic        base_offset;
  logic        hist_rd_en;
  logic [8:0]  hist_rd_addr;
  logic [19:0] hist_rd_data;
  logic        hist_clr_en;
  logic [8:0]  hist_clr_addr;
  logic        cdf_wr_en;
  logic [8:0]  cdf_wr_addr;
  logic [19:0] cdf_wr_data;
  logic [19:0] Cdf_Min;
  logic        cdf_valid;
  logic        cdf_error;
  logic        busy;
  modport slave (
    input  cdf_start, base_offset, hist_rd_data,
    output hist_rd_en, hist_rd_addr, hist_clr_en, hist_clr_addr,
           cdf_wr_en, cdf_wr_addr, cdf_wr_data, Cdf_Min, cdf_valid, cdf_error, busy
  );
  modport master (
    output cdf_start, base_offset, hist_rd_data,
    input  hist_rd_en, hist_rd_addr, hist_clr_en, hist_clr_addr,
           cdf_wr_en, cdf_wr_addr, cdf_wr_data, Cdf_Min, cdf_valid, cdf_error, busy
  );
endinterface

// File: rtl/cdf_builder.sv
// cdf_builder: read-and-clear a 256-bin histogram bank into a saturating running-sum CDF bank
module cdf_builder #(
  parameter int TOTAL_PIXELS = 307200,
  parameter int BINS         = 256
) (
  input logic          clock,
  input logic          reset_n,
  cdf_builder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, DRAIN, FINISH, REPORT} state_t;
  state_t      state;
  logic        bank;
  logic [19:0] sum;
  logic [19:0] min_reg;
  logic        min_found;
  logic        err;
  logic [20:0] sum_ext;
  logic [19:0] sum_next;
  logic        last_bin;
  // saturating accumulate of the returning bin count
  always_comb begin
    sum_ext  = {1'b0, sum} + {1'b0, bus.hist_rd_data};
    sum_next = sum_ext[20] ? 20'hFFFFF : sum_ext[19:0];
    last_bin = bus.hist_rd_addr[7:0] == 8'(BINS - 1);
  end
  // read/clear/write pipeline (clear tracks read by one cycle, write by two) and the build FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      bank              <= 1'b0;
      sum               <= '0;
      min_reg           <= '0;
      min_found         <= 1'b0;
      err               <= 1'b0;
      bus.hist_rd_en    <= 1'b0;
      bus.hist_rd_addr  <= '0;
      bus.hist_clr_en   <= 1'b0;
      bus.hist_clr_addr <= '0;
      bus.cdf_wr_en     <= 1'b0;
      bus.cdf_wr_addr   <= '0;
      bus.cdf_wr_data   <= '0;
      bus.Cdf_Min       <= '0;
      bus.cdf_valid     <= 1'b0;
      bus.cdf_error     <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      bus.hist_clr_en   <= bus.hist_rd_en;
      bus.hist_clr_addr <= bus.hist_rd_addr;
      bus.cdf_wr_en     <= bus.hist_clr_en;
      bus.cdf_valid     <= 1'b0;
      if (bus.hist_clr_en) begin
        sum             <= sum_next;
        err             <= err | sum_ext[20];
        bus.cdf_wr_addr <= bus.hist_clr_addr;
        bus.cdf_wr_data <= sum_next;
        if (!min_found && bus.hist_rd_data != '0) begin
          min_reg   <= sum_next;
          min_found <= 1'b1;
        end
      end
      case (state)
        IDLE: if (bus.cdf_start) begin
          bank             <= bus.base_offset;
          sum              <= '0;
          min_reg          <= '0;
          min_found        <= 1'b0;
          err              <= 1'b0;
          bus.hist_rd_en   <= 1'b1;
          bus.hist_rd_addr <= {bus.base_offset, 8'd0};
          bus.busy         <= 1'b1;
          state            <= READ;
        end
        READ: if (last_bin) begin
          bus.hist_rd_en <= 1'b0;
          state          <= DRAIN;
        end else begin
          bus.hist_rd_addr <= {bank, bus.hist_rd_addr[7:0] + 8'd1};
        end
        DRAIN: state <= FINISH;
        FINISH: begin
          bus.Cdf_Min   <= min_found ? min_reg : '0;
          bus.cdf_error <= err | (sum != 20'(TOTAL_PIXELS)) | ~min_found;
          bus.cdf_valid <= 1'b1;
          state         <= REPORT;
        end
        REPORT: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
